run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Run/debug sequencer for the single-cycle RISC-V core.
- Gates every architectural state update (PC advance, register-file write, data-memory write) through one enable: `core_en`.
- Accepts host commands: halt, run, single-step, set PC, breakpoint control.
- Stops the core on breakpoint or EBREAK before that instruction retires, and counts retired instructions.

Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 32'h0000_0000, PC value loaded after reset
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  command accepted this cycle when valid&&ready
- cmd_op  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 SET_PC
- cmd_data  in  XLEN  operand for SET_BP/SET_PC
- pc_cur  in  XLEN  current PC register output
- instr  in  32  instruction fetched at pc_cur
- core_en  out  1  1 = current instruction retires (PC, RU, DM writes enabled)
- pc_load  out  1  force PC register to pc_load_val at next edge
- pc_load_val  out  XLEN  forced PC value
- halted  out  1  core stopped
- halt_cause  out  2  0 RESET, 1 CMD, 2 BP, 3 EBREAK
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States: INIT, HALTED, RUN, STEP.
- Reset (async, any time incl. mid-run) forces:
  - state=INIT, instret=0, bp_valid=0, bp_addr=0, resume=0, halt_cause=RESET.
  - Outputs during reset: core_en=0, halted=1, cmd_ready=0, pc_load=1, pc_load_val=RESET_PC.
- INIT: pc_load=1, pc_load_val=RESET_PC for exactly one cycle, then HALTED. cmd_ready=0.
- HALTED:
  - cmd_ready=1; core_en=0.
  - RUN → RUN; STEP → STEP; both set resume=1.
  - SET_PC → pc_load=1 combinationally that cycle, pc_load_val=cmd_data; state stays HALTED.
  - SET_BP → bp_addr=cmd_data, bp_valid=1. CLR_BP → bp_valid=0.
  - HALT/NOP → no effect.
- Halt-hit is combinational and evaluated in RUN/STEP:
  - ebreak_hit = (instr==32'h0010_0073).
  - bp_hit = bp_valid && pc_cur==bp_addr && !resume.
  - Priority: EBREAK > BP > CMD.
- core_en = (RUN||STEP) && !ebreak_hit && !bp_hit. The hit instruction does not retire and PC holds.
- RUN:
  - cmd_ready = (cmd_op==HALT). All other ops stall with cmd_ready=0.
  - On hit → HALTED with cause EBREAK/BP.
  - Else if HALT accepted → the current instruction still retires (core_en=1), then HALTED, cause CMD.
- STEP:
  - cmd_ready=0.
  - Retires exactly one instruction, then HALTED, cause CMD.
  - Because resume=1, a breakpoint never blocks the step. EBREAK still blocks it: core_en=0, cause EBREAK.
- resume clears on the first edge where core_en=1. This lets RUN continue past the breakpoint it stopped at.
- halted=1 in INIT/HALTED, else 0.
- halt_cause updates only on the transition into HALTED and holds otherwise.
- instret += 1 at each edge where core_en=1; wraps modulo 2^CNT_W silently.
- pc_load is never asserted in RUN/STEP; pc_load and core_en are mutually exclusive.

Optional Feature:
- Macro RUN_CTRL_BP_EN.
- Defined: breakpoint register and bp_hit as above.
- Undefined:
  - bp_valid/bp_addr are absent and bp_hit=0.
  - SET_BP/CLR_BP are still accepted (cmd_ready per state) with no effect.
  - halt_cause never reads BP.

Decomposition:
- Package run_ctrl_pkg holds:
  - cmd_op_e enum (3-bit), state_e enum, halt_cause_e enum (2-bit).
  - Localparam EBREAK_INSN=32'h0010_0073.
- No sub-module; the counter and breakpoint compare stay inline.

Test Plan:
- Reset release → one cycle pc_load=1, pc_load_val=0 → halted=1, halt_cause=0, instret=0, core_en=0.
- HALTED, SET_PC 0x40 then STEP → pc_load pulse with 0x40; STEP gives one core_en=1 cycle → instret=1, halted=1, halt_cause=1.
- SET_BP 0x10, RUN from 0x0 with sequential code → core_en=1 for 4 cycles, 0 when pc_cur=0x10 → halted, cause 2, instret=4. RUN again → 0x10 retires, counter continues.
- RUN, instr=0x00100073 at 0x8 → core_en=0 that cycle, halted, cause 3. HALT issued in the same cycle → cause still 3.
- RUN, HALT asserted in a non-hit cycle → cmd_ready=1, that instruction retires, next cycle halted, cause 1. A RUN command while running → cmd_ready=0.
- Assert rst mid-RUN with instret=0x1234 and bp set → immediately core_en=0, instret=0, bp cleared; after release INIT reloads RESET_PC.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run/debug sequencer.
//   cmd_op_e     - host command encoding (3 bits)
//   state_e      - sequencer state (INIT, HALTED, RUN, STEP)
//   halt_cause_e - reason the core last stopped (2 bits)
//   EBREAK_INSN  - RV32 EBREAK encoding that stops the core before retiring
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_HALT   = 3'd1,
        OP_RUN    = 3'd2,
        OP_STEP   = 3'd3,
        OP_SET_BP = 3'd4,
        OP_CLR_BP = 3'd5,
        OP_SET_PC = 3'd6,
        OP_RSVD   = 3'd7
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_HALTED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_RESET  = 2'd0,
        CAUSE_CMD    = 2'd1,
        CAUSE_BP     = 2'd2,
        CAUSE_EBREAK = 2'd3
    } halt_cause_e;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/run_ctrl.sv
// run_ctrl: run/debug sequencer for the single-cycle RISC-V core.
// Every architectural update of the core (PC advance, register write,
// data-memory write) is gated by core_en. The host halts, runs,
// single-steps, sets the PC and manages a breakpoint through a command port.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   host command handshake
//   cmd_op, cmd_data  command opcode and operand (SET_BP / SET_PC)
//   pc_cur, instr     current PC and the instruction fetched there
//   core_en           1 = the current instruction retires this cycle
//   pc_load(_val)     force the core PC at the next edge
//   halted            core stopped (INIT or HALTED)
//   halt_cause        reason for the last stop (RESET/CMD/BP/EBREAK)
//   instret           retired-instruction counter (wraps)
//   dbg_state         current sequencer state, for observation
//
// Optional feature: define RUN_CTRL_BP_EN to build the breakpoint register.
// Without it SET_BP/CLR_BP are accepted but do nothing and BP never fires.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is a function of state and cmd_op only; the host holds cmd_op and
// cmd_data stable while cmd_valid is high and not yet accepted.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [XLEN-1:0]  cmd_data,
    input  logic [XLEN-1:0]  pc_cur,
    input  logic [31:0]      instr,
    output logic             core_en,
    output logic             pc_load,
    output logic [XLEN-1:0]  pc_load_val,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instret,
    output logic [1:0]       dbg_state
);

    state_e      state, state_nxt;
    halt_cause_e cause_q, cause_nxt;
    cmd_op_e     op;
    logic        resume;
    logic        resume_set;
    logic        bp_wr;
    logic        bp_clr;
    logic        active;
    logic        ebreak_hit;
    logic        bp_hit;

    assign op     = cmd_op_e'(cmd_op);
    assign active = (state == ST_RUN) || (state == ST_STEP);

    assign ebreak_hit = active && (instr == EBREAK_INSN);

`ifdef RUN_CTRL_BP_EN
    logic            bp_valid;
    logic [XLEN-1:0] bp_addr;

    // resume masks the breakpoint we just stopped at until one instruction
    // has retired, so RUN/STEP can move past it.
    assign bp_hit = active && bp_valid && (pc_cur == bp_addr) && !resume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_valid <= 1'b0;
            bp_addr  <= '0;
        end else if (bp_wr) begin
            bp_valid <= 1'b1;
            bp_addr  <= cmd_data;
        end else if (bp_clr) begin
            bp_valid <= 1'b0;
        end
    end
`else
    logic unused_bp;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{pc_cur, bp_wr, bp_clr, resume};
`endif

    always_comb begin
        state_nxt   = state;
        cause_nxt   = cause_q;
        core_en     = 1'b0;
        cmd_ready   = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = RESET_PC;
        halted      = 1'b0;
        resume_set  = 1'b0;
        bp_wr       = 1'b0;
        bp_clr      = 1'b0;
        case (state)
            ST_INIT: begin
                halted    = 1'b1;
                pc_load   = 1'b1;
                state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                halted    = 1'b1;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (op)
                        OP_RUN: begin
                            state_nxt  = ST_RUN;
                            resume_set = 1'b1;
                        end
                        OP_STEP: begin
                            state_nxt  = ST_STEP;
                            resume_set = 1'b1;
                        end
                        OP_SET_PC: begin
                            pc_load     = 1'b1;
                            pc_load_val = cmd_data;
                        end
                        OP_SET_BP: bp_wr  = 1'b1;
                        OP_CLR_BP: bp_clr = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Only HALT is accepted while running; everything else stalls.
                cmd_ready = (op == OP_HALT);
                core_en   = !ebreak_hit && !bp_hit;
                if (ebreak_hit) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_EBREAK;
                end else if (bp_hit) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_BP;
                end else if (cmd_valid && (op == OP_HALT)) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_CMD;
                end
            end
            ST_STEP: begin
                core_en   = !ebreak_hit && !bp_hit;
                state_nxt = ST_HALTED;
                if (ebreak_hit)  cause_nxt = CAUSE_EBREAK;
                else if (bp_hit) cause_nxt = CAUSE_BP;
                else             cause_nxt = CAUSE_CMD;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            cause_q <= CAUSE_RESET;
            instret <= '0;
            resume  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            if (core_en) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            if (resume_set)   resume <= 1'b1;
            else if (core_en) resume <= 1'b0;
        end
    end

    assign halt_cause = cause_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl. A small core stand-in owns the PC
// (load / +4 on retire) and serves NOP everywhere except one EBREAK address.
// A behavioural model tracks mode, counter, breakpoint and cause, and is
// compared against the DUT on every falling edge; directed steps add
// hand-computed literal checks.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int          XLEN     = 32;
    localparam int          CNT_W    = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef RUN_CTRL_BP_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [XLEN-1:0]  cmd_data;
    logic [XLEN-1:0]  pc_cur;
    logic [31:0]      instr;
    logic             core_en;
    logic             pc_load;
    logic [XLEN-1:0]  pc_load_val;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] instret;
    logic [1:0]       dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [37:0] exp_q[$];

    run_ctrl #(.XLEN(XLEN), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .pc_cur(pc_cur), .instr(instr),
        .core_en(core_en), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .halted(halted), .halt_cause(halt_cause), .instret(instret),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- core stand-in ----------------
    logic [31:0] pc;
    logic [31:0] ebreak_pc;

    always @(posedge clk or posedge rst) begin
        if (rst)          pc <= RESET_PC;
        else if (pc_load) pc <= pc_load_val;
        else if (core_en) pc <= pc + 32'd4;
    end
    assign pc_cur = pc;
    assign instr  = (pc == ebreak_pc) ? EBREAK_INSN : 32'h0000_0013;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_booting, m_stopped, m_single, m_bp_set, m_fresh;
    logic [31:0] m_count, m_bp_pc;
    logic [1:0]  m_cause;
    bit          n_booting, n_stopped, n_single, n_bp_set, n_fresh;
    logic [31:0] n_count, n_bp_pc;
    logic [1:0]  n_cause;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_booting <= 1'b1; m_stopped <= 1'b0; m_single <= 1'b0;
            m_bp_set  <= 1'b0; m_bp_pc   <= '0;   m_fresh  <= 1'b0;
            m_count   <= '0;   m_cause   <= 2'd0;
        end else begin
            m_booting <= n_booting; m_stopped <= n_stopped; m_single <= n_single;
            m_bp_set  <= n_bp_set;  m_bp_pc   <= n_bp_pc;   m_fresh  <= n_fresh;
            m_count   <= n_count;   m_cause   <= n_cause;
        end
    end

    always @(negedge clk) begin
        bit          e_en, e_rdy, e_load, e_halt, hit_e, hit_b;
        logic [31:0] e_val;
        logic [37:0] e;
        e_en = 0; e_rdy = 0; e_load = 0; e_halt = 0; e_val = RESET_PC;
        n_booting = m_booting; n_stopped = m_stopped; n_single = m_single;
        n_bp_set = m_bp_set; n_bp_pc = m_bp_pc; n_fresh = m_fresh;
        n_count = m_count; n_cause = m_cause;
        if (m_booting) begin
            e_load = 1; e_halt = 1;
            n_booting = 0; n_stopped = 1;
        end else if (m_stopped) begin
            e_halt = 1; e_rdy = 1;
            if (cmd_valid) begin
                case (cmd_op)
                    3'd2: begin n_stopped = 0; n_single = 0; n_fresh = 1; end
                    3'd3: begin n_stopped = 0; n_single = 1; n_fresh = 1; end
                    3'd4: begin n_bp_set = BP_EN; n_bp_pc = cmd_data; end
                    3'd5: n_bp_set = 0;
                    3'd6: begin e_load = 1; e_val = cmd_data; end
                    default: ;
                endcase
            end
        end else begin
            hit_e = (instr == 32'h0010_0073);
            hit_b = m_bp_set && (pc_cur == m_bp_pc) && !m_fresh;
            e_en  = !hit_e && !hit_b;
            e_rdy = !m_single && (cmd_op == 3'd1);
            if (e_en) begin n_count = m_count + 1; n_fresh = 0; end
            if (hit_e)       begin n_stopped = 1; n_cause = 2'd3; end
            else if (hit_b)  begin n_stopped = 1; n_cause = 2'd2; end
            else if (m_single || (cmd_valid && cmd_op == 3'd1)) begin
                n_stopped = 1; n_cause = 2'd1;
            end
        end
        exp_q.push_back({e_en, e_rdy, e_load, e_halt, m_cause, m_count});
        e = exp_q.pop_front();
        chk("core_en",    core_en,    e[37]);
        chk("cmd_ready",  cmd_ready,  e[36]);
        chk("pc_load",    pc_load,    e[35]);
        chk("halted",     halted,     e[34]);
        chk("halt_cause", halt_cause, e[33:32]);
        chk("instret",    instret,    e[31:0]);
        if (e_load) chk("pc_load_val", pc_load_val, e_val);
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] op, input logic [31:0] data);
        bit ok = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_op = op; cmd_data = data;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) chk("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_op = 0; cmd_data = 0;
    endtask

    task automatic wait_halted(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) begin ok = 1; break; end
        end
        if (!ok) chk("halt_timeout", 0, 1);
    endtask

    task automatic wait_pc(input logic [31:0] addr, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (pc == addr) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("pc_wait_timeout", 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        cmd_valid = 0; cmd_op = 0; cmd_data = 0;
        ebreak_pc = 32'hFFFF_FFF0;
        rst = 0;
        #1 rst = 1;

        // reset outputs
        @(negedge clk);
        chk("rst_core_en", core_en, 0);
        chk("rst_halted", halted, 1);
        chk("rst_pc_load", pc_load, 1);
        chk("rst_pc_load_val", pc_load_val, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("init_pc_load", pc_load, 1);
        chk("init_pc_load_val", pc_load_val, 32'h0);
        @(negedge clk);
        chk("post_init_halted", halted, 1);
        chk("post_init_cause", halt_cause, 0);
        chk("post_init_instret", instret, 0);
        chk("post_init_pc_load", pc_load, 0);

        // SET_PC 0x40 then STEP
        @(posedge clk); #1;
        cmd_valid = 1; cmd_op = 3'd6; cmd_data = 32'h40;
        @(negedge clk);
        chk("setpc_pc_load", pc_load, 1);
        chk("setpc_val", pc_load_val, 32'h40);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_op = 0; cmd_data = 0;
        issue(3'd3, 0);
        @(negedge clk);
        chk("step_core_en", core_en, 1);
        @(negedge clk);
        chk("step_halted", halted, 1);
        chk("step_cause", halt_cause, 1);
        chk("step_instret", instret, 1);
        chk("step_pc", pc, 32'h44);

        // breakpoint at 0x10, EBREAK at 0x20
        ebreak_pc = 32'h20;
        issue(3'd6, 32'h0);
        issue(3'd4, 32'h10);
        issue(3'd2, 0);
        wait_halted(40);
        chk("bp_cause", halt_cause, BP_EN ? 2'd2 : 2'd3);
        chk("bp_instret", instret, BP_EN ? 32'd5 : 32'd9);
        chk("bp_pc", pc, BP_EN ? 32'h10 : 32'h20);
        issue(3'd2, 0);
        wait_halted(40);
        chk("resume_cause", halt_cause, 3);
        chk("resume_instret", instret, 9);
        chk("resume_pc", pc, 32'h20);

        // EBREAK at 0x8 with a HALT in the same cycle
        issue(3'd5, 0);
        ebreak_pc = 32'h8;
        issue(3'd6, 32'h0);
        issue(3'd2, 0);
        wait_pc(32'h8, 20);
        cmd_valid = 1; cmd_op = 3'd1;
        @(negedge clk);
        chk("ebreak_core_en", core_en, 0);
        chk("ebreak_halt_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_op = 0;
        @(negedge clk);
        chk("ebreak_halted", halted, 1);
        chk("ebreak_cause", halt_cause, 3);
        chk("ebreak_instret", instret, 11);
        chk("ebreak_pc", pc, 32'h8);

        // RUN while running stalls; HALT on a normal cycle retires it
        ebreak_pc = 32'h100;
        issue(3'd6, 32'h0);
        issue(3'd2, 0);
        wait_pc(32'h4, 20);
        cmd_valid = 1; cmd_op = 3'd2;
        @(negedge clk);
        chk("run_while_running_ready", cmd_ready, 0);
        chk("run_while_running_en", core_en, 1);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_op = 0;
        wait_pc(32'hC, 20);
        cmd_valid = 1; cmd_op = 3'd1;
        @(negedge clk);
        chk("halt_ready", cmd_ready, 1);
        chk("halt_retires", core_en, 1);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_op = 0;
        @(negedge clk);
        chk("halt_halted", halted, 1);
        chk("halt_cause", halt_cause, 1);
        chk("halt_instret", instret, 15);
        chk("halt_pc", pc, 32'h10);

        // long run up to instret = 0x1234
        ebreak_pc = (32'h1234 - 32'd15) * 32'd4;
        issue(3'd6, 32'h0);
        issue(3'd2, 0);
        wait_halted(5000);
        chk("long_instret", instret, 32'h1234);
        chk("long_cause", halt_cause, 3);

        // reset in the middle of a run with a breakpoint armed
        ebreak_pc = 32'h100;
        issue(3'd4, 32'h40);
        issue(3'd6, 32'h0);
        issue(3'd2, 0);
        wait_pc(32'h10, 20);
        #1 rst = 1;
        #1;
        chk("midrst_core_en", core_en, 0);
        chk("midrst_instret", instret, 0);
        chk("midrst_halted", halted, 1);
        chk("midrst_pc_load", pc_load, 1);
        chk("midrst_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("midrst_init_load", pc_load, 1);
        chk("midrst_init_val", pc_load_val, 32'h0);
        issue(3'd2, 0);
        wait_pc(32'h48, 40);
        @(negedge clk);
        chk("bp_cleared_running", halted, 0);
        issue(3'd1, 0);
        @(negedge clk);
        chk("final_halted", halted, 1);
        chk("final_cause", halt_cause, 1);
        chk("final_instret", instret, 20);
        chk("final_pc", pc, 32'h50);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim did not finish, want finish before 2000000");
        $fatal(1, "timeout");
    end

endmodule
